// File: rtl/mul_rr_sched.sv
// Round-robin front end for one shared integer multiplier: grants one requester at a time,
// registers its operands and mode, and returns the product with the requester ID.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitrating; req_ready driven to the round-robin winner, if any
// CALC  | operands and mode pins presented to the multiplier; product captured
// RESP  | response held on rsp_* until the consumer takes it
module mul_rr_sched #(
    parameter int NUM_REQ            = 4,
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ID_W               = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]                    req_apx,
    output logic [DATA_PATH_BITWIDTH-1:0]         mul_a,
    output logic [DATA_PATH_BITWIDTH-1:0]         mul_b,
    output logic                                  mul_racc,
    output logic                                  mul_rapx,
    input  logic [DATA_PATH_BITWIDTH-1:0]         mul_d,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_PATH_BITWIDTH-1:0]         rsp_d,
    output logic [ID_W-1:0]                       rsp_id,
    output logic                                  busy
);

    localparam int W = DATA_PATH_BITWIDTH;

    // The modulo wrap of the round-robin search relies on ID_W bits covering NUM_REQ exactly.
    if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0 || (1 << ID_W) != NUM_REQ || OP_BITWIDTH < 1)
    begin : g_bad_params
        $error("mul_rr_sched: NUM_REQ must be a power of two >= 2 with ID_W = log2(NUM_REQ)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic            mul_racc_q, mul_racc_d;
    logic            mul_rapx_q, mul_rapx_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_d_q, rsp_d_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic            busy_q, busy_d;

    logic [ID_W-1:0] gnt_id;
    logic            gnt_vld;
    logic [ID_W-1:0] scan_idx;
    logic            hs;

    // Scan from farthest to nearest so the requester closest after last_q overwrites the rest.
    always_comb begin
        gnt_id   = '0;
        gnt_vld  = 1'b0;
        scan_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = last_q + ID_W'(k);
            if (req_valid[scan_idx]) begin
                gnt_id  = scan_idx;
                gnt_vld = 1'b1;
            end
        end
    end

    // A reset in the same cycle as a request must not let the requester believe it was taken.
    assign hs = (state_q == IDLE) && gnt_vld && !rst;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = hs && (gnt_id == ID_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_racc_d  = mul_racc_q;
        mul_rapx_d  = mul_rapx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d_d     = rsp_d_q;
        rsp_id_d    = rsp_id_q;
        id_d        = id_q;
        last_d      = last_q;

        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    mul_a_d    = req_a[int'(gnt_id)*W +: W];
                    mul_b_d    = req_b[int'(gnt_id)*W +: W];
                    mul_rapx_d = req_apx[gnt_id];
                    mul_racc_d = ~req_apx[gnt_id];
                    id_d       = gnt_id;
                    last_d     = gnt_id;
                    state_d    = CALC;
                end
            end
            CALC: begin
                rsp_d_d     = mul_d;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    mul_racc_d  = 1'b0;
                    mul_rapx_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_racc_q  <= 1'b0;
            mul_rapx_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_d_q     <= '0;
            rsp_id_q    <= '0;
            id_q        <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_racc_q  <= mul_racc_d;
            mul_rapx_q  <= mul_rapx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_d_q     <= rsp_d_d;
            rsp_id_q    <= rsp_id_d;
            id_q        <= id_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_racc  = mul_racc_q;
    assign mul_rapx  = mul_rapx_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_d     = rsp_d_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model of the scheduler with an exact multiplier stand-in.
module tb_mul_rr_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_apx;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_racc;
    logic            mul_rapx;
    logic [W-1:0]    mul_d;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_d;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    always #5 clk = ~clk;

    // Stand-in for the shared multiplier: low W bits of the unsigned product.
    assign mul_d = W'(32'(mul_a) * 32'(mul_b));

    mul_rr_sched #(
        .NUM_REQ           (N),
        .OP_BITWIDTH       (16),
        .DATA_PATH_BITWIDTH(W),
        .ID_W              (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_apx  (req_apx),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_racc (mul_racc),
        .mul_rapx (mul_rapx),
        .mul_d    (mul_d),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_d    (rsp_d),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = waiting for a request, 1 = computing, 2 = response pending.
    int        m_phase = 0;
    int        m_last  = N - 1;
    logic [W-1:0] m_a, m_b, m_d;
    int        m_id;
    logic      m_apx;
    int        cyc = 0;
    int        grant_q[$];
    int        gcyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic apx);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_apx[i]      = apx;
    endtask

    task automatic rand_ops();
        req_a   = {$urandom, $urandom};
        req_b   = {$urandom, $urandom};
        req_apx = N'($urandom);
    endtask

    // One clock: check every visible output against the model, advance the model, clock the DUT.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = -1;
        if (!rst && m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        if (m_phase != 0) begin
            chk("mul_a", 32'(mul_a), 32'(m_a));
            chk("mul_b", 32'(mul_b), 32'(m_b));
            chk("mul_rapx", 32'(mul_rapx), 32'(m_apx));
            chk("mul_racc", 32'(mul_racc), 32'(!m_apx));
        end else begin
            chk("mode_idle", 32'({mul_racc, mul_rapx}), 32'd0);
        end
        if (m_phase == 2) begin
            chk("rsp_d", 32'(rsp_d), 32'(m_d));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end

        if (rst) begin
            m_phase = 0;
            m_last  = N - 1;
        end else if (m_phase == 0) begin
            if (g >= 0) begin
                m_a   = req_a[g*W +: W];
                m_b   = req_b[g*W +: W];
                m_apx = req_apx[g];
                m_d   = W'((32'(m_a) * 32'(m_b)) % 65536);
                m_id  = g;
                m_last = g;
                m_phase = 1;
                grant_q.push_back(g);
                gcyc_q.push_back(cyc);
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_apx   = '0;
        rsp_ready = 1'b0;

        // Reset values, sampled while rst is still held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_rsp_d", 32'(rsp_d), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_mode", 32'({mul_racc, mul_rapx}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single request, accurate mode.
        rsp_ready = 1'b1;
        set_op(1, 16'd3, 16'd5, 1'b0);
        req_valid = 4'b0010;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("single_racc", 32'(mul_racc), 32'd1);
        chk("single_rapx", 32'(mul_rapx), 32'd0);
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_d", 32'(rsp_d), 32'd15);
        chk("single_rsp_id", 32'(rsp_id), 32'd1);
        step();
        chk("single_back_idle", 32'(busy), 32'd0);
        step();

        // Truncation, approximate mode.
        set_op(0, 16'hFFFF, 16'h0002, 1'b1);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("trunc_calc_mode", 32'({mul_racc, mul_rapx}), 32'b01);
        step();
        chk("trunc_rsp_d", 32'(rsp_d), 32'hFFFE);
        chk("trunc_resp_mode", 32'({mul_racc, mul_rapx}), 32'b01);
        step();
        step();

        // Contention from a fresh reset: grants rotate 0,1,2,3,0,1 three cycles apart.
        rst = 1'b1;
        step();
        rst = 1'b0;
        grant_q.delete();
        gcyc_q.delete();
        req_valid = 4'b1111;
        for (int s = 0; s < 18; s++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        chk("cont_grant_count", 32'(grant_q.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            chk("cont_grant_order", 32'(grant_q[i]), 32'(i % N));
            if (i > 0) chk("cont_grant_gap", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd3);
        end
        while (m_phase != 0 && cyc < 1000) step();

        // Back-pressure: five stalled RESP cycles with every requester clamouring.
        rsp_ready = 1'b0;
        rand_ops();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1111;
        step();
        for (int s = 0; s < 5; s++) step();
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        chk("bp_released", 32'(rsp_valid), 32'd0);
        step();

        // Reset in CALC discards the operation; then 0 beats 2 on a fresh pointer.
        rand_ops();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0001;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '0;
        chk("midrst_mul_a", 32'(mul_a), 32'd0);
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        grant_q.delete();
        req_valid = 4'b0101;
        step();
        req_valid = '0;
        chk("midrst_first_grant", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 32'd0);
        for (int s = 0; s < 4; s++) step();

        // Random traffic.
        for (int s = 0; s < 400; s++) begin
            rand_ops();
            req_valid = N'($urandom_range(0, 15));
            rsp_ready = 1'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_rr_sched.md
# mul_rr_sched

Round-robin scheduler that shares one configurable integer multiplier (`conf_int_mul__noFF__arch_agnos__w_wrapper`) among `NUM_REQ` requesters.

- Arbitrates among requesters and accepts one operand pair per grant.
- Registers the operands and drives the multiplier's `racc`/`rapx` mode pins from the winner's accuracy request.
- Captures the product and returns it with the requester ID over a valid/ready response port.
- Sits between the PE operand queues and the single shared multiplier instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; a power of two, at least 2.
- `OP_BITWIDTH`, 16: operator bit width; passed to the multiplier unchanged.
- `DATA_PATH_BITWIDTH`, 16: operand and result width (W).
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  NUM_REQ*W  packed operand A; requester i occupies bits `[i*W +: W]`.
- `req_b`  in  NUM_REQ*W  packed operand B, same packing.
- `req_apx`  in  NUM_REQ  per-requester mode: 1 = approximate, 0 = accurate.
- `mul_a`, `mul_b`  out  W  registered operands to the multiplier.
- `mul_racc`, `mul_rapx`  out  1  multiplier mode pins.
- `mul_d`  in  W  multiplier result (combinational from `mul_a`/`mul_b`).
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_d`  out  W  result.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_d`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- Reset values:
  - state = IDLE.
  - `mul_a`, `mul_b`, `rsp_d`, `rsp_id` = 0.
  - `mul_racc` = `mul_rapx` = `rsp_valid` = `busy` = 0.
  - Round-robin pointer `last` = NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - Winner `g` = the first `i` with `req_valid[i]`=1, searching `last+1`, `last+2`, … modulo NUM_REQ.
  - `req_ready[g]`=1 combinationally in the same cycle; all other `req_ready` bits are 0.
  - Handshake completes in that cycle. On the edge:
    - `mul_a`←A[g], `mul_b`←B[g].
    - `mul_rapx`←`req_apx[g]`, `mul_racc`←`~req_apx[g]`.
    - `id_q`←g, `last`←g.
    - State → CALC.
  - With no `req_valid` set: `req_ready`=0 and the FSM stays in IDLE.
- CALC:
  - `req_ready`=0.
  - On the edge: `rsp_d`←`mul_d`, `rsp_id`←`id_q`, `rsp_valid`←1, state → RESP.
- RESP:
  - `rsp_valid`=1; `rsp_d` and `rsp_id` are held stable; `req_ready`=0.
  - When `rsp_ready`=1 on an edge: `rsp_valid`←0, `mul_racc`←0, `mul_rapx`←0, state → IDLE.
- Mode pins: `mul_racc` and `mul_rapx` are one-hot in CALC and RESP and both 0 in IDLE.
- Arithmetic:
  - `rsp_d` is `mul_d` taken verbatim: the low W bits of the unsigned product.
  - No saturation and no sign handling.
- Back-pressure and fairness:
  - A requester may deassert `req_valid` before it is granted; no state is kept for it.
  - `last` advances only on a completed handshake.
- `rsp_ready` is ignored outside RESP.

## Timing
- Request accepted at edge t: `mul_*` valid after t; `rsp_valid`=1 after edge t+1.
- Minimum request-to-response latency is 2 cycles.
- Peak throughput is one operation per 3 cycles, reached when `rsp_ready` is held at 1.
- Each cycle that `rsp_ready` is low in RESP adds one cycle.
- `req_ready` is combinational from state and `req_valid`, and is never registered.
- `rsp_valid`, `rsp_d`, `rsp_id`, `mul_*` and `busy` are all registered outputs.
- `rst` mid-operation:
  - The next edge forces the reset values.
  - The in-flight result is discarded and no response is produced.
  - `last` returns to NUM_REQ-1.
- A `rst` asserted together with a handshake wins: nothing is latched.

## Test plan
- **Reset values:** hold `rst` for 2 cycles → all outputs 0, `req_ready`=0, `busy`=0.
- **Single request, accurate mode:** requester 1 sends A=3, B=5, apx=0, with `rsp_ready`=1 → `req_ready`=4'b0010 in the same cycle.
  - `mul_racc`=1 and `mul_rapx`=0 in CALC.
  - `rsp_valid` rises 2 cycles later with `rsp_d`=15, `rsp_id`=1.
  - The FSM returns to IDLE on the next edge.
- **Truncation, approximate mode:** requester 0 sends A=16'hFFFF, B=16'h0002, apx=1 → `rsp_d`=16'hFFFE, `mul_rapx`=1, `mul_racc`=0 during CALC and RESP.
- **Contention:** all four requesters hold `req_valid` continuously → grant order is 0,1,2,3,0,1.
  - Successive grants are 3 cycles apart.
  - Each `rsp_id` matches its grant.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_d` and `rsp_id` stay stable and `req_ready`=0 throughout; release completes the transfer in 1 cycle.
- **Reset mid-operation:** assert `rst` in CALC → no `rsp_valid` ever appears for that operation.
  - After reset, with requesters 2 and 0 both valid, requester 0 is granted first.
